// File: rtl/root_power_bank.sv
// Twiddle-factor bank for an NTT butterfly array.
// Each lane holds a W table and a WQ table of DEPTH rows, each row being
// E/2 words of FSIZE bits, with per-word write enables. A small FSM tracks
// whether the tables hold a complete load (EMPTY -> LOAD -> READY).
//
// Read handshake: rd_en is a strobe with no back-pressure. Every cycle in
// which rd_en is high yields exactly one cycle of rd_valid two cycles later,
// carrying the row addressed by rd_addr. Back-to-back strobes stream one row
// per cycle. rd_W/rd_WQ are zero whenever rd_valid is low. Reads are
// never refused; a read while not ready still returns data and raises the
// sticky rd_err flag.
module root_power_bank #(
    parameter int FSIZE = 64,
    parameter int E     = 8,
    parameter int N     = 4096,
    parameter int LOGE  = 3,
    localparam int DEPTH = N / (E / 2),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 rd_en,
    input  logic [LOGE-1:0][AW-1:0]              rd_addr,
    output logic                                 rd_valid,
    output logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  rd_W,
    output logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  rd_WQ,
    input  logic [LOGE-1:0][AW-1:0]              W_waddr,
    input  logic [LOGE-1:0][AW-1:0]              WQ_waddr,
    input  logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  W_wdata,
    input  logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  WQ_wdata,
    input  logic [LOGE-1:0][E/2-1:0]             W_wren,
    input  logic [LOGE-1:0][E/2-1:0]             WQ_wren,
    input  logic                                 load_start,
    input  logic                                 load_done,
    output logic                                 ready,
    output logic                                 rd_err,
    output logic [AW:0]                          wr_count,
    output logic [1:0]                           fsm_state
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    state_t state;
    state_t state_next;

    // Stage-1 read valid and the per-lane array read results.
    logic                                 rd_v1;
    logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  w_rd;
    logic [LOGE-1:0][E/2-1:0][FSIZE-1:0]  wq_rd;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_start dominates load_done in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (load_start) state_next = S_LOAD;
            S_LOAD: begin
                if (load_start)     state_next = S_LOAD;
                else if (load_done) state_next = S_READY;
            end
            S_READY: if (load_start) state_next = S_LOAD;
            default: state_next = S_EMPTY;
        endcase
    end

    assign ready     = (state == S_READY);
    assign fsm_state = state;

    // Rows written in the current load, counted on lane 0 W activity only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_count <= '0;
        end else if (load_start) begin
            wr_count <= '0;
        end else if ((|W_wren[0]) && (wr_count != DEPTH_CNT)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Sticky error for reads issued outside READY; a new load clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_err <= 1'b0;
        end else if (load_start) begin
            rd_err <= 1'b0;
        end else if (rd_en && !ready) begin
            rd_err <= 1'b1;
        end
    end

    // Per-lane storage. The array is read on the same edge that captures
    // the request, so a write to the same row in that cycle is not seen
    // (read-first). Contents are deliberately left unreset.
    for (genvar g = 0; g < LOGE; g++) begin : g_lane
        logic [E/2-1:0][FSIZE-1:0] w_mem  [DEPTH];
        logic [E/2-1:0][FSIZE-1:0] wq_mem [DEPTH];
        logic [E/2-1:0][FSIZE-1:0] w_q;
        logic [E/2-1:0][FSIZE-1:0] wq_q;

        // Word-granular writes and the registered array read.
        always_ff @(posedge clk) begin
            for (int k = 0; k < E / 2; k++) begin
                if (W_wren[g][k])  w_mem[W_waddr[g]][k]   <= W_wdata[g][k];
                if (WQ_wren[g][k]) wq_mem[WQ_waddr[g]][k] <= WQ_wdata[g][k];
            end
            if (rd_en) begin
                w_q  <= w_mem[rd_addr[g]];
                wq_q <= wq_mem[rd_addr[g]];
            end
        end

        assign w_rd[g]  = w_q;
        assign wq_rd[g] = wq_q;
    end

    // Read pipeline control and output register; reset drops in-flight reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_v1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_W     <= '0;
            rd_WQ    <= '0;
        end else begin
            rd_v1    <= rd_en;
            rd_valid <= rd_v1;
            rd_W     <= rd_v1 ? w_rd  : '0;
            rd_WQ    <= rd_v1 ? wq_rd : '0;
        end
    end

endmodule

// File: tb/tb_root_power_bank.sv
// Self-checking bench for root_power_bank: a table of control vectors,
// hand-written corner sequences and a randomized phase, all checked
// against a behavioural model of the tables and the load handshake.
module tb_root_power_bank;

    localparam int FSIZE = 64;
    localparam int E     = 8;
    localparam int N     = 4096;
    localparam int LOGE  = 3;
    localparam int W2    = E / 2;
    localparam int DEPTH = N / W2;
    localparam int AW    = $clog2(DEPTH);
    localparam int RWID  = W2 * FSIZE;

    localparam int M_EMPTY = 0;
    localparam int M_LOAD  = 1;
    localparam int M_READY = 2;

    typedef logic [W2-1:0][FSIZE-1:0]          row_t;
    typedef logic [LOGE-1:0][W2-1:0][FSIZE-1:0] lanes_t;
    typedef struct packed {
        logic   v;
        lanes_t w;
        lanes_t wq;
    } exp_t;

    typedef struct {
        logic ls, ld, rd, wr;
        logic ex_ready, ex_err;
        int   ex_cnt;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b1;
    logic                      rd_en;
    logic [LOGE-1:0][AW-1:0]   rd_addr;
    logic                      rd_valid;
    lanes_t                    rd_W, rd_WQ;
    logic [LOGE-1:0][AW-1:0]   W_waddr, WQ_waddr;
    lanes_t                    W_wdata, WQ_wdata;
    logic [LOGE-1:0][W2-1:0]   W_wren, WQ_wren;
    logic                      load_start, load_done;
    logic                      ready, rd_err;
    logic [AW:0]               wr_count;
    logic [1:0]                fsm_state;

    root_power_bank #(.FSIZE(FSIZE), .E(E), .N(N), .LOGE(LOGE)) dut (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_W(rd_W), .rd_WQ(rd_WQ),
        .W_waddr(W_waddr), .WQ_waddr(WQ_waddr),
        .W_wdata(W_wdata), .WQ_wdata(WQ_wdata),
        .W_wren(W_wren), .WQ_wren(WQ_wren),
        .load_start(load_start), .load_done(load_done),
        .ready(ready), .rd_err(rd_err), .wr_count(wr_count),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual timeout required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    row_t m_w  [LOGE][DEPTH];
    row_t m_wq [LOGE][DEPTH];
    int   m_state;
    logic m_err;
    int   m_cnt;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [RWID-1:0] act, input logic [RWID-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    function automatic row_t fill_row(input logic [FSIZE-1:0] v);
        row_t r;
        for (int k = 0; k < W2; k++) r[k] = v;
        return r;
    endfunction

    function automatic logic [FSIZE-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en      = 1'b0;
        load_start = 1'b0;
        load_done  = 1'b0;
        W_wren     = '0;
        WQ_wren    = '0;
    endtask

    task automatic model_reset();
        m_state = M_EMPTY;
        m_err   = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        #2;
        chk("reset_valid", RWID'(rd_valid), '0);
        chk("reset_ready", RWID'(ready), '0);
        chk("reset_err",   RWID'(rd_err), '0);
        chk("reset_cnt",   RWID'(wr_count), '0);
        chk("reset_rdW",   RWID'(rd_W[0]), '0);
        step();
        step();
        rstn = 1'b1;
        model_reset();
    endtask

    // One clock: predict, apply the edge, compare everything observable.
    task automatic cycle();
        exp_t e;
        e   = '0;
        e.v = rd_en;
        if (rd_en) begin
            for (int l = 0; l < LOGE; l++) begin
                e.w[l]  = m_w[l][rd_addr[l]];
                e.wq[l] = m_wq[l][rd_addr[l]];
            end
        end
        exp_q.push_back(e);

        if (load_start) m_err = 1'b0;
        else if (rd_en && m_state != M_READY) m_err = 1'b1;

        if (load_start) m_cnt = 0;
        else if ((|W_wren[0]) && m_cnt < DEPTH) m_cnt = m_cnt + 1;

        if (load_start) m_state = M_LOAD;
        else if (load_done && m_state == M_LOAD) m_state = M_READY;

        for (int l = 0; l < LOGE; l++) begin
            for (int k = 0; k < W2; k++) begin
                if (W_wren[l][k])  m_w[l][W_waddr[l]][k]   = W_wdata[l][k];
                if (WQ_wren[l][k]) m_wq[l][WQ_waddr[l]][k] = WQ_wdata[l][k];
            end
        end

        step();

        e = exp_q.pop_front();
        chk("rd_valid", RWID'(rd_valid), RWID'(e.v));
        for (int l = 0; l < LOGE; l++) begin
            chk($sformatf("rd_W[%0d]", l),  rd_W[l],  e.w[l]);
            chk($sformatf("rd_WQ[%0d]", l), rd_WQ[l], e.wq[l]);
        end
        chk("ready",    RWID'(ready),    RWID'(m_state == M_READY));
        chk("rd_err",   RWID'(rd_err),   RWID'(m_err));
        chk("wr_count", RWID'(wr_count), RWID'(m_cnt));
    endtask

    task automatic write_lane0(input int row, input logic [FSIZE-1:0] wv, input logic [FSIZE-1:0] wqv);
        W_waddr[0]  = AW'(row);
        WQ_waddr[0] = AW'(row);
        W_wdata[0]  = fill_row(wv);
        WQ_wdata[0] = fill_row(wqv);
        W_wren[0]   = '1;
        WQ_wren[0]  = '1;
    endtask

    // ---------------- test ----------------
    initial begin
        idle();
        rd_addr = '0; W_waddr = '0; WQ_waddr = '0; W_wdata = '0; WQ_wdata = '0;

        tbl[0]  = '{ls:0, ld:0, rd:0, wr:0, ex_ready:0, ex_err:0, ex_cnt:0};
        tbl[1]  = '{ls:0, ld:1, rd:0, wr:0, ex_ready:0, ex_err:0, ex_cnt:0};
        tbl[2]  = '{ls:0, ld:0, rd:1, wr:0, ex_ready:0, ex_err:1, ex_cnt:0};
        tbl[3]  = '{ls:0, ld:0, rd:1, wr:1, ex_ready:0, ex_err:1, ex_cnt:1};
        tbl[4]  = '{ls:1, ld:0, rd:0, wr:0, ex_ready:0, ex_err:0, ex_cnt:0};
        tbl[5]  = '{ls:0, ld:0, rd:0, wr:1, ex_ready:0, ex_err:0, ex_cnt:1};
        tbl[6]  = '{ls:0, ld:0, rd:1, wr:1, ex_ready:0, ex_err:1, ex_cnt:2};
        tbl[7]  = '{ls:0, ld:1, rd:0, wr:0, ex_ready:1, ex_err:1, ex_cnt:2};
        tbl[8]  = '{ls:0, ld:0, rd:1, wr:0, ex_ready:1, ex_err:1, ex_cnt:2};
        tbl[9]  = '{ls:1, ld:1, rd:0, wr:1, ex_ready:0, ex_err:0, ex_cnt:0};
        tbl[10] = '{ls:0, ld:1, rd:0, wr:0, ex_ready:1, ex_err:0, ex_cnt:0};
        tbl[11] = '{ls:1, ld:0, rd:1, wr:0, ex_ready:0, ex_err:0, ex_cnt:0};
        tbl[12] = '{ls:0, ld:0, rd:1, wr:0, ex_ready:0, ex_err:1, ex_cnt:0};

        do_reset();

        // Fill every row of every lane, then overrun lane 0 by three rows.
        load_start = 1'b1;
        cycle();
        idle();
        for (int r = 0; r < DEPTH + 3; r++) begin
            for (int l = 0; l < LOGE; l++) begin
                W_waddr[l]  = AW'(r % DEPTH);
                WQ_waddr[l] = AW'(r % DEPTH);
                for (int k = 0; k < W2; k++) begin
                    W_wdata[l][k]  = rnd64();
                    WQ_wdata[l][k] = rnd64();
                end
                W_wren[l]  = (r < DEPTH || l == 0) ? '1 : '0;
                WQ_wren[l] = (r < DEPTH || l == 0) ? '1 : '0;
            end
            cycle();
        end
        idle();
        chk("sat_wr_count", RWID'(wr_count), RWID'(DEPTH));
        load_start = 1'b1;
        load_done  = 1'b1;
        cycle();
        idle();
        chk("start_done_ready", RWID'(ready), '0);
        chk("start_done_cnt",   RWID'(wr_count), '0);

        // Control vectors from a fresh reset; contents survive the reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            idle();
            load_start = tbl[i].ls;
            load_done  = tbl[i].ld;
            rd_en      = tbl[i].rd;
            for (int l = 0; l < LOGE; l++) rd_addr[l] = AW'($urandom_range(0, DEPTH - 1));
            if (tbl[i].wr) begin
                W_waddr[0]    = AW'($urandom_range(0, DEPTH - 1));
                W_wdata[0][0] = rnd64();
                W_wren[0][0]  = 1'b1;
            end
            cycle();
            chk($sformatf("tbl%0d_ready", i), RWID'(ready),    RWID'(tbl[i].ex_ready));
            chk($sformatf("tbl%0d_err", i),   RWID'(rd_err),   RWID'(tbl[i].ex_err));
            chk($sformatf("tbl%0d_cnt", i),   RWID'(wr_count), RWID'(tbl[i].ex_cnt));
        end

        // Basic load and read of lane 0 row 5.
        do_reset();
        idle(); load_start = 1'b1; cycle();
        idle(); write_lane0(5, 64'h11, 64'h22); cycle();
        idle(); load_done = 1'b1; cycle();
        idle(); rd_en = 1'b1; rd_addr[0] = AW'(5); cycle();
        chk("basic_ready", RWID'(ready), RWID'(1));
        idle(); cycle();
        chk("basic_valid", RWID'(rd_valid), RWID'(1));
        chk("basic_W",  rd_W[0],  fill_row(64'h11));
        chk("basic_WQ", rd_WQ[0], fill_row(64'h22));

        // Streaming reads of rows 0..7 holding their own index.
        for (int k = 0; k < 8; k++) begin
            idle(); write_lane0(k, FSIZE'(k), FSIZE'(k)); cycle();
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i < 8) begin
                rd_en = 1'b1;
                for (int l = 0; l < LOGE; l++) rd_addr[l] = AW'(i);
            end
            cycle();
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream%0d_valid", i - 1), RWID'(rd_valid), RWID'(1));
                chk($sformatf("stream%0d_W", i - 1), rd_W[0], fill_row(FSIZE'(i - 1)));
            end else if (i == 9) begin
                chk("stream_end_valid", RWID'(rd_valid), '0);
                chk("stream_end_W", rd_W[0], '0);
            end
        end

        // Same-cycle read and write of one row returns the old contents.
        idle(); write_lane0(3, 64'h55, 64'h55); cycle();
        idle(); write_lane0(3, 64'hAA, 64'hAA); rd_en = 1'b1; rd_addr[0] = AW'(3); cycle();
        idle(); rd_en = 1'b1; rd_addr[0] = AW'(3); cycle();
        chk("rfirst_old", rd_W[0], fill_row(64'h55));
        idle(); cycle();
        chk("rfirst_new", rd_W[0], fill_row(64'hAA));

        // Randomized traffic concentrated on a few rows to force collisions.
        for (int i = 0; i < 400; i++) begin
            idle();
            load_start = ($urandom_range(0, 39) == 0);
            load_done  = ($urandom_range(0, 9) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            for (int l = 0; l < LOGE; l++) begin
                rd_addr[l]  = AW'($urandom_range(0, 7));
                W_waddr[l]  = AW'($urandom_range(0, 7));
                WQ_waddr[l] = AW'($urandom_range(0, 7));
                for (int k = 0; k < W2; k++) begin
                    W_wdata[l][k]  = rnd64();
                    WQ_wdata[l][k] = rnd64();
                    W_wren[l][k]   = ($urandom_range(0, 2) == 0);
                    WQ_wren[l][k]  = ($urandom_range(0, 2) == 0);
                end
            end
            cycle();
        end

        // Reset one cycle after a read drops it; data survives a reload.
        idle(); rd_en = 1'b1;
        for (int l = 0; l < LOGE; l++) rd_addr[l] = AW'($urandom_range(0, DEPTH - 1));
        cycle();
        idle();
        rstn = 1'b0;
        #2;
        chk("midread_valid", RWID'(rd_valid), '0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); cycle();
            chk("post_reset_valid", RWID'(rd_valid), '0);
            chk("post_reset_ready", RWID'(ready), '0);
        end
        idle(); load_start = 1'b1; cycle();
        idle(); load_done = 1'b1; cycle();
        for (int i = 0; i < 6; i++) begin
            idle(); rd_en = 1'b1;
            for (int l = 0; l < LOGE; l++) rd_addr[l] = AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        idle(); cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/root_power_bank.md
ROOT_POWER_BANK -- requirements
Module: root_power_bank

Interface
REQ-001 Parameter FSIZE, default 64: twiddle word width in bits.
REQ-002 Parameter E, default 8: butterfly radix; each lane holds E/2 words per row.
REQ-003 Parameter N, default 4096: polynomial degree; DEPTH = N/(E/2) rows, AW = clog2(DEPTH).
REQ-004 Parameter LOGE, default 3: number of independent lanes, equal to log2(E).
REQ-005 clk  in  1  single clock; all state is rising-edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 rd_en  in  1  read request strobe from the interconnect.
REQ-008 rd_addr  in  LOGE x AW  per-lane row address.
REQ-009 rd_valid  out  1  read data valid.
REQ-010 rd_W, rd_WQ  out  LOGE x E/2 x FSIZE  W and WQ row data per lane.
REQ-011 W_waddr, WQ_waddr  in  LOGE x AW  per-lane write row.
REQ-012 W_wdata, WQ_wdata  in  LOGE x E/2 x FSIZE  write data.
REQ-013 W_wren, WQ_wren  in  LOGE x E/2  per-word write enables.
REQ-014 load_start  in  1  pulse that begins a table reload.
REQ-015 load_done  in  1  pulse that ends a table reload.
REQ-016 ready  out  1  table valid for reads.
REQ-017 rd_err  out  1  sticky flag: read issued while not ready.
REQ-018 wr_count  out  AW+1  count of W rows written in the current load, saturating.

Function
REQ-019 Storage: per lane, two DEPTH x (E/2 x FSIZE) arrays (W, WQ), word-granular write enable.
REQ-020 FSM states: EMPTY, LOAD, READY.
REQ-021 EMPTY -> LOAD on load_start; LOAD -> READY on load_done; READY -> LOAD on load_start; all other inputs hold state.
REQ-022 load_start and load_done in the same cycle: load_start wins (LOAD entered or kept).
REQ-023 ready = 1 only in READY.
REQ-024 Writes are accepted in every state; a word is written when its wren bit is 1.
REQ-025 wr_count clears to 0 on load_start, increments by 1 for each cycle in which lane 0 has any W_wren bit set, and saturates at DEPTH.
REQ-026 Read latency is exactly 2 cycles: rd_en at edge t gives rd_valid = 1 and data at edge t+2, via an address register stage and a RAM output register stage.
REQ-027 Back-to-back rd_en sustains one read per cycle with no bubbles.
REQ-028 rd_valid = 0 gives rd_W and rd_WQ = 0.
REQ-029 A read and a write to the same lane and row in the same cycle returns the old data (read-first).
REQ-030 A read issued when not ready still returns array contents with rd_valid, and sets rd_err.
REQ-031 rd_err clears only on reset or load_start.
REQ-032 Lanes are fully independent; addresses need not match across lanes.
REQ-033 Out-of-range addresses cannot occur: AW bits exactly address DEPTH rows, so rows wrap naturally.

Reset
REQ-034 On rstn low, asynchronously: state = EMPTY, ready = 0, rd_valid = 0, rd_W and rd_WQ = 0, rd_err = 0, wr_count = 0, and the read pipeline is flushed.
REQ-035 Array contents are not reset.
REQ-036 Reset asserted mid-read drops in-flight reads; no rd_valid appears after rstn rises without a new rd_en.

Verification
REQ-037 Reset, load_start, write lane 0 row 5 W = 0x11 and WQ = 0x22 (all words), load_done, then rd_en with lane 0 addr 5 -> ready = 1; two cycles later rd_valid = 1, rd_W[0] = 0x11 words, rd_WQ[0] = 0x22 words.
REQ-038 Eight consecutive rd_en cycles on rows 0..7 after loading row k = k -> rd_valid high for 8 consecutive cycles starting 2 cycles later, data 0..7 in order.
REQ-039 Same cycle write row 3 = 0xAA (old value 0x55) and read row 3 -> read returns 0x55; a following read returns 0xAA.
REQ-040 rd_en while EMPTY -> rd_err = 1 and stays 1 through later reads; load_start -> rd_err = 0.
REQ-041 load_start, then DEPTH+3 cycles of lane-0 W writes -> wr_count = DEPTH (saturated); load_start and load_done in the same cycle -> state LOAD, ready = 0, wr_count = 0.
REQ-042 rstn pulsed low one cycle after rd_en -> no rd_valid follows, ready = 0, and previously written data is still readable after a reload handshake.
